// File: rtl/system_0_led_sequencer.sv
// LED pattern sequencer: CPU-configured Avalon-MM slave, sole master writing the LED PIO.
// Emits a one-cycle write strobe of the current pattern every max(PERIOD,2) clocks.
module system_0_led_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata
);

    typedef enum logic [1:0] {IDLE, WRITE, WAIT} state_t;

    state_t      state, state_nxt;
    logic        enable;
    logic [1:0]  mode;
    logic [23:0] period;
    logic [7:0]  pattern;
    logic        pending;
    logic [7:0]  cur;
    logic        dir;
    logic [15:0] count;
    logic [23:0] timer;

    logic cfg_wr, start, advance;
    assign cfg_wr  = s_chipselect && !s_write_n;
    assign start   = (state == IDLE) && enable;
    assign advance = (state == WAIT) && enable && (timer == 24'd0);

    logic unused_wdata;
    assign unused_wdata = ^s_writedata[31:24];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable  <= 1'b0;
            mode    <= 2'd0;
            period  <= 24'd0;
            pattern <= 8'd0;
        end else if (cfg_wr) begin
            case (s_address)
                2'd0: begin
                    enable <= s_writedata[0];
                    mode   <= s_writedata[2:1];
                end
                2'd1:    period  <= s_writedata[23:0];
                2'd2:    pattern <= s_writedata[7:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = WRITE;
            WRITE:   state_nxt = enable ? WAIT : IDLE;
            WAIT:    if (!enable) state_nxt = IDLE;
                     else if (timer == 24'd0) state_nxt = WRITE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_chipselect = (state == WRITE);
        m_write_n    = !(state == WRITE);
    end

    // A PATTERN write wins over the clear, so a write landing on an update edge
    // is honoured at the following update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          pending <= 1'b0;
        else if (cfg_wr && s_address == 2'd2)  pending <= 1'b1;
        else if (start || (advance && pending)) pending <= 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur   <= 8'd0;
            dir   <= 1'b0;
            count <= 16'd0;
            timer <= 24'd0;
        end else begin
            case (state)
                IDLE: if (enable) begin
                    cur   <= pattern;
                    dir   <= 1'b0;
                    count <= 16'd0;
                end
                WRITE: begin
                    count <= count + 16'd1;
                    timer <= (period < 24'd2) ? 24'd0 : period - 24'd2;
                end
                WAIT: if (enable) begin
                    if (timer != 24'd0) begin
                        timer <= timer - 24'd1;
                    end else if (pending) begin
                        cur <= pattern;
                        dir <= 1'b0;
                    end else begin
                        case (mode)
                            2'd0: cur <= pattern;
                            2'd1: cur <= {cur[6:0], cur[7]};
                            2'd2: begin
                                if (!dir) begin
                                    if (cur[7]) begin dir <= 1'b1; cur <= cur >> 1; end
                                    else        cur <= cur << 1;
                                end else begin
                                    if (cur[0]) begin dir <= 1'b0; cur <= cur << 1; end
                                    else        cur <= cur >> 1;
                                end
                            end
                            default: cur <= cur + 8'd1;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        s_readdata = 32'd0;
        case (s_address)
            2'd0: s_readdata = {29'd0, mode, enable};
            2'd1: s_readdata = {8'd0, period};
            2'd2: s_readdata = {24'd0, pattern};
            2'd3: s_readdata = {count, 6'd0, dir, (state != IDLE), cur};
            default: ;
        endcase
    end

    assign m_address   = 2'd0;
    assign m_writedata = {24'd0, cur};

endmodule

// File: tb/tb_system_0_led_sequencer.sv
// Scoreboard bench for the LED sequencer: expected strobes (data + cycle) are queued
// as stimulus is driven and checked by a negedge monitor; tasks check readback inline.
module tb_system_0_led_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  s_address = 2'd0;
    logic        s_chipselect = 1'b0;
    logic        s_write_n = 1'b1;
    logic [31:0] s_writedata = 32'd0;
    logic [31:0] s_readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    system_0_led_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .s_address(s_address), .s_chipselect(s_chipselect), .s_write_n(s_write_n),
        .s_writedata(s_writedata), .s_readdata(s_readdata),
        .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
        .m_writedata(m_writedata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every strobe must match the head of the scoreboard in data and cycle.
    always @(negedge clk) begin
        if (m_chipselect && !m_write_n) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL strobe_unexpected cyc=%0d data=%h", cyc, m_writedata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (m_writedata !== {24'd0, e.data} || cyc !== e.cyc || m_address !== 2'd0) begin
                    miscompares++;
                    $display("FAIL strobe got data=%h cyc=%0d addr=%0d want data=%h cyc=%0d addr=0",
                             m_writedata, cyc, m_address, e.data, e.cyc);
                end
            end
        end
    end

    function automatic void push(input logic [7:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        sb.push_back(e);
    endfunction

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d, output int c);
        s_address = a; s_writedata = d; s_chipselect = 1'b1; s_write_n = 1'b0;
        c = cyc;
        @(posedge clk); #1;
        s_chipselect = 1'b0; s_write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        s_address = a;
        #1;
        d = s_readdata;
    endtask

    task automatic wait_cyc(input int x);
        while (cyc < x) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        if (sb.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL %s drain: %0d strobes missing, want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        int c;
        logic [31:0] d;
        #1;
        vectors++;
        if (m_chipselect !== 1'b0 || m_write_n !== 1'b1 || m_address !== 2'd0 || m_writedata !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got cs=%b wn=%b addr=%0d data=%h want cs=0 wn=1 addr=0 data=0",
                     m_chipselect, m_write_n, m_address, m_writedata);
        end
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], d);
            vectors++;
            if (d !== 32'd0) begin
                miscompares++;
                $display("FAIL reset_readback[%0d] got %h want 0", a, d);
            end
        end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        // Reset while in WAIT: registers clear asynchronously.
        cfg_write(2'd2, 32'h81, c); cfg_write(2'd1, 32'd10, c); cfg_write(2'd0, 32'h3, c);
        push(8'h81, c + 2);
        wait_cyc(c + 5);
        reset_n = 1'b0;
        #1;
        rd(2'd0, d);
        vectors++;
        if (m_chipselect !== 1'b0 || m_write_n !== 1'b1 || d !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid_wait got cs=%b wn=%b ctrl=%h want cs=0 wn=1 ctrl=0", m_chipselect, m_write_n, d);
        end
        rd(2'd3, d);
        vectors++;
        if (d !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid_wait_status got %h want 0", d);
        end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        wait_cyc(cyc + 15);
        rd(2'd3, d);
        vectors++;
        if (d !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_release_status got %h want 0", d);
        end
        // Reset during a strobe cycle must drop the strobe immediately.
        cfg_write(2'd2, 32'h81, c); cfg_write(2'd1, 32'd10, c); cfg_write(2'd0, 32'h3, c);
        push(8'h81, c + 2);
        wait_cyc(c + 2);
        @(negedge clk); #1;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (m_chipselect !== 1'b0 || m_write_n !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_write got cs=%b wn=%b want cs=0 wn=1", m_chipselect, m_write_n);
        end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        wait_drain("reset");
    endtask

    task automatic test_rotate();
        int c, c2;
        logic [31:0] d;
        logic [7:0] e[4] = '{8'h81, 8'h03, 8'h06, 8'h0C};
        cfg_write(2'd2, 32'h81, c); cfg_write(2'd1, 32'd4, c); cfg_write(2'd0, 32'h3, c);
        for (int k = 0; k < 4; k++) push(e[k], c + 2 + 4 * k);
        for (int k = 0; k < 4; k++) begin
            wait_cyc(c + 3 + 4 * k);
            rd(2'd3, d);
            vectors++;
            if (d !== {16'(k + 1), 6'd0, 1'b0, 1'b1, e[k]}) begin
                miscompares++;
                $display("FAIL rotate_status[%0d] got %h want %h", k, d, {16'(k + 1), 6'd0, 1'b0, 1'b1, e[k]});
            end
        end
        cfg_write(2'd0, 32'h0, c2);
        wait_drain("rotate");
    endtask

    task automatic test_bounce();
        int c, c2;
        logic [31:0] d;
        cfg_write(2'd2, 32'h40, c); cfg_write(2'd1, 32'd2, c); cfg_write(2'd0, 32'h5, c);
        push(8'h40, c + 2); push(8'h80, c + 4); push(8'h40, c + 6); push(8'h20, c + 8);
        wait_cyc(c + 4);
        rd(2'd3, d);
        vectors++;
        if (d[9] !== 1'b0) begin
            miscompares++;
            $display("FAIL bounce_dir_before got %b want 0", d[9]);
        end
        wait_cyc(c + 6);
        rd(2'd3, d);
        vectors++;
        if (d[9] !== 1'b1) begin
            miscompares++;
            $display("FAIL bounce_dir_after got %b want 1", d[9]);
        end
        wait_cyc(c + 8);
        cfg_write(2'd0, 32'h0, c2);
        wait_drain("bounce");
    endtask

    task automatic test_count();
        int c, c2;
        logic [31:0] d;
        cfg_write(2'd2, 32'hFE, c); cfg_write(2'd1, 32'd0, c); cfg_write(2'd0, 32'h7, c);
        push(8'hFE, c + 2); push(8'hFF, c + 4); push(8'h00, c + 6); push(8'h01, c + 8);
        wait_cyc(c + 8);
        rd(2'd0, d);
        vectors++;
        if (d !== 32'h7) begin
            miscompares++;
            $display("FAIL count_ctrl_readback got %h want 7", d);
        end
        cfg_write(2'd0, 32'h0, c2);
        wait_drain("count");
    endtask

    task automatic test_pattern_pending();
        int c, c2, s4;
        cfg_write(2'd2, 32'h01, c); cfg_write(2'd1, 32'd4, c); cfg_write(2'd0, 32'h3, c);
        s4 = c + 2 + 12;
        push(8'h01, c + 2); push(8'h02, c + 6); push(8'h11, c + 10); push(8'h22, s4);
        push(8'h44, s4 + 4); push(8'h11, s4 + 8); push(8'h22, s4 + 12);
        wait_cyc(c + 7);
        cfg_write(2'd2, 32'h11, c2);
        wait_cyc(s4 + 3);
        cfg_write(2'd2, 32'h11, c2);
        wait_cyc(s4 + 12);
        cfg_write(2'd0, 32'h0, c2);
        wait_drain("pending");
    endtask

    task automatic test_back_to_back();
        int c, c2, s2;
        logic [31:0] d;
        cfg_write(2'd2, 32'h81, c); cfg_write(2'd1, 32'd6, c); cfg_write(2'd0, 32'h3, c);
        s2 = c + 8;
        push(8'h81, c + 2); push(8'h03, s2);
        wait_cyc(s2 + 2);
        cfg_write(2'd0, 32'h0, c2);
        wait_cyc(s2 + 5);
        rd(2'd3, d);
        vectors++;
        if (d !== 32'h0002_0003) begin
            miscompares++;
            $display("FAIL disable_status got %h want 00020003", d);
        end
        wait_cyc(s2 + 14);
        cfg_write(2'd0, 32'h3, c);
        push(8'h81, c + 2);
        wait_cyc(c + 3);
        rd(2'd3, d);
        vectors++;
        if (d !== 32'h0001_0181) begin
            miscompares++;
            $display("FAIL reenable_status got %h want 00010181", d);
        end
        cfg_write(2'd0, 32'h0, c2);
        wait_drain("reenable");
    endtask

    initial begin
        test_reset();
        test_rotate();
        test_bounce();
        test_count();
        test_pattern_pending();
        test_back_to_back();
        wait_cyc(cyc + 10);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
